// File: rtl/dsm_sample_sequencer.sv
// dsm_sample_sequencer: first-order delta-sigma loop that holds each handshaked sample for OSR steps
module dsm_sample_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDITIONAL_DELTA_WIDTH = 1,
  parameter int FEEDBACK_MAG = 1,
  parameter int ACC_WIDTH = 8,
  parameter int OSR = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear_flags,
  input  logic                  i_tick,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_bit,
  output logic                  o_bit_valid,
  output logic                  o_busy,
  output logic                  o_underrun,
  output logic                  o_sat
);
  localparam int DLW = DATA_WIDTH + ADDITIONAL_DELTA_WIDTH;
  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [DLW-1:0] FB = DLW'(FEEDBACK_MAG);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RUN = 2'd2;

  logic [1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, buf_q, buf_d;
  logic buf_full_q, buf_full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_new;
  logic q_q, q_d, bit_q, bit_d, bit_valid_q, bit_valid_d;
  logic underrun_q, underrun_d, sat_q, sat_d;
  logic hs, step, win_end, clamp, unr_set;
  logic [DLW-1:0] delta;
  logic [ACC_WIDTH:0] sum;

  assign o_data_ready = state_q == WAIT || (state_q == RUN && !buf_full_q);
  assign o_busy = state_q != IDLE;
  assign o_bit = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_underrun = underrun_q;
  assign o_sat = sat_q;
  assign hs = i_data_valid && o_data_ready;
  assign step = state_q == RUN && i_tick;
  assign win_end = step && cnt_q == LAST;
  assign delta = {{ADDITIONAL_DELTA_WIDTH{hold_q[DATA_WIDTH-1]}}, hold_q} - (q_q ? FB : -FB);
  assign sum = {acc_q[ACC_WIDTH-1], acc_q} + {{(ACC_WIDTH + 1 - DLW){delta[DLW-1]}}, delta};
  // the extra sum bit disagrees with the acc sign bit exactly when the result left the acc range
  assign clamp = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign acc_new = clamp ? {sum[ACC_WIDTH], {(ACC_WIDTH - 1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    buf_d = buf_q;
    buf_full_d = buf_full_q;
    cnt_d = cnt_q;
    acc_d = step ? acc_new : acc_q;
    q_d = step ? ~acc_new[ACC_WIDTH-1] : q_q;
    bit_d = step ? ~acc_new[ACC_WIDTH-1] : bit_q;
    bit_valid_d = step;
    unr_set = 1'b0;
    if (state_q == IDLE) begin
      state_d = i_enable ? WAIT : IDLE;
    end else if (state_q == WAIT) begin
      if (hs) begin
        hold_d = i_data;
        cnt_d = '0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (hs) begin
        buf_d = i_data;
        buf_full_d = 1'b1;
      end
      if (step) cnt_d = win_end ? '0 : cnt_q + 1'b1;
      if (win_end) begin
        if (!i_enable) begin
          state_d = IDLE;
          acc_d = '0;
          q_d = 1'b0;
          buf_d = '0;
          buf_full_d = 1'b0;
        end else if (buf_full_q) begin
          hold_d = buf_q;
          buf_full_d = 1'b0;
        end else if (hs) begin
          hold_d = i_data;
          buf_full_d = 1'b0;
        end else begin
          unr_set = 1'b1;
        end
      end
    end
    underrun_d = unr_set || (underrun_q && !i_clear_flags);
    sat_d = (step && clamp) || (sat_q && !i_clear_flags);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      buf_q <= '0;
      buf_full_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= 1'b0;
      bit_q <= 1'b0;
      bit_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      buf_q <= buf_d;
      buf_full_q <= buf_full_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q <= q_d;
      bit_q <= bit_d;
      bit_valid_q <= bit_valid_d;
      underrun_q <= underrun_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// tb_dsm_sample_sequencer: vector table plus hand sequences, bitstream checked through an expected-bit queue
`timescale 1ns/1ps
module tb_dsm_sample_sequencer;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_enable = 1'b0;
  logic i_clear_flags = 1'b0;
  logic i_tick = 1'b0;
  logic i_data_valid = 1'b0;
  logic [3:0] i_data = 4'h0;
  logic o_data_ready, o_bit, o_bit_valid, o_busy, o_underrun, o_sat;
  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  typedef struct {
    logic [3:0] data;
    int n;
    logic [7:0] bits;
    int sat_step;
    int unr_step;
  } vec_t;
  vec_t vecs[6];

  dsm_sample_sequencer #(
    .DATA_WIDTH(4),
    .ADDITIONAL_DELTA_WIDTH(1),
    .FEEDBACK_MAG(1),
    .ACC_WIDTH(6),
    .OSR(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_enable(i_enable),
    .i_clear_flags(i_clear_flags),
    .i_tick(i_tick),
    .i_data(i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .o_bit(o_bit),
    .o_bit_valid(o_bit_valid),
    .o_busy(o_busy),
    .o_underrun(o_underrun),
    .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    if (o_bit_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_bit_valid: got o_bit_valid=1 expected no pending step at %0t", $time);
      end else begin
        chk("o_bit", o_bit, exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic [3:0] d);
    @(negedge i_clk);
    i_enable = 1'b1;
    @(negedge i_clk);
    chk("wait_ready", o_data_ready, 1);
    i_data = d;
    i_data_valid = 1'b1;
    i_tick = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_tick = 1'b0;
    chk("run_busy", o_busy, 1);
  endtask

  task automatic step(input logic b);
    i_tick = 1'b1;
    exp_q.push_back(b);
    @(negedge i_clk);
  endtask

  task automatic clear_flags();
    i_clear_flags = 1'b1;
    @(negedge i_clk);
    i_clear_flags = 1'b0;
    chk("sat_cleared", o_sat, 0);
    chk("underrun_cleared", o_underrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'h0, 4, 8'b0000_1011, 0, 0};
    vecs[1] = '{4'h7, 8, 8'hFF, 5, 4};
    vecs[2] = '{4'hF, 4, 8'b0000_0001, 0, 0};
    vecs[3] = '{4'h8, 8, 8'h00, 5, 4};
    vecs[4] = '{4'hC, 4, 8'h00, 0, 0};
    vecs[5] = '{4'h5, 4, 8'h0F, 0, 0};

    @(negedge i_clk);
    chk("rst_ready", o_data_ready, 0);
    chk("rst_bit", o_bit, 0);
    chk("rst_bit_valid", o_bit_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_sat", o_sat, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_ready", o_data_ready, 0);

    start(4'h7);
    for (int k = 0; k < 3; k++) step(1'b1);
    i_tick = 1'b0;
    chk("pre_rst_bit", o_bit, 1);
    chk("pre_rst_valid", o_bit_valid, 1);
    #1 i_rst = 1'b1;
    #1;
    chk("async_rst_ready", o_data_ready, 0);
    chk("async_rst_bit", o_bit, 0);
    chk("async_rst_valid", o_bit_valid, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_underrun", o_underrun, 0);
    chk("async_rst_sat", o_sat, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ready", o_data_ready, 1);

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].data);
      for (int k = 0; k < vecs[i].n; k++) begin
        i_enable = k < vecs[i].n - 4;
        step(vecs[i].bits[k]);
        chk("vec_sat", o_sat, vecs[i].sat_step != 0 && k + 1 >= vecs[i].sat_step);
        if (k < vecs[i].n - 1) begin
          chk("vec_underrun", o_underrun, vecs[i].unr_step != 0 && k + 1 >= vecs[i].unr_step);
          chk("vec_ready", o_data_ready, 1);
        end
      end
      i_tick = 1'b0;
      chk("vec_end_busy", o_busy, 0);
      chk("vec_end_ready", o_data_ready, 0);
      chk("vec_drained", exp_q.size(), 0);
      clear_flags();
    end

    start(4'h0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b2b_bits;
      b2b_bits = 8'b1111_1011;
      i_enable = k < 4;
      i_data_valid = k == 1;
      i_data = 4'h7;
      step(b2b_bits[k]);
      i_data_valid = 1'b0;
      chk("b2b_valid", o_bit_valid, 1);
      chk("b2b_ready", o_data_ready, !(k == 1 || k == 2 || k == 7));
      if (k >= 3) chk("b2b_underrun", o_underrun, 0);
      chk("b2b_sat", o_sat, 0);
    end
    i_tick = 1'b0;
    chk("b2b_idle", o_busy, 0);

    start(4'h3);
    for (int k = 0; k < 4; k++) begin
      i_enable = k < 2;
      i_data_valid = k == 2;
      i_data = 4'h5;
      step(1'b1);
      i_data_valid = 1'b0;
      if (k == 2) chk("dis_buf_ready", o_data_ready, 0);
    end
    i_tick = 1'b0;
    chk("dis_busy", o_busy, 0);
    chk("dis_ready", o_data_ready, 0);
    start(4'hF);
    chk("dis_buf_dropped", o_data_ready, 1);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] m1_bits;
      m1_bits = 4'b0001;
      i_enable = 1'b0;
      step(m1_bits[k]);
    end
    i_tick = 1'b0;
    chk("dis_c_idle", o_busy, 0);

    start(4'h7);
    for (int k = 0; k < 8; k++) begin
      i_enable = k < 4;
      i_clear_flags = k == 4;
      step(1'b1);
      i_clear_flags = 1'b0;
      chk("setwin_sat", o_sat, k >= 4);
      if (k >= 3 && k <= 6) chk("setwin_underrun", o_underrun, k == 3);
    end
    i_tick = 1'b0;
    clear_flags();

    repeat (2) @(negedge i_clk);
    chk("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsm_sample_sequencer.md
Name: dsm_sample_sequencer

Overview:
- Sequences a first-order delta-sigma modulator loop: accepts input samples over a valid/ready handshake and holds each one for OSR modulator steps.
- On each step it computes the delta-feedback term, updates a saturating integrator, quantizes to one bit and emits the bitstream.
- Sits between the sample source (filter/interpolator) and the 1-bit output driver, and owns all loop state.

Parameters:
- DATA_WIDTH, 4: signed input sample width.
- ADDITIONAL_DELTA_WIDTH, 1: extra delta bits; DELTA_WIDTH = DATA_WIDTH+ADDITIONAL_DELTA_WIDTH.
- FEEDBACK_MAG, 1: feedback magnitude, subtracted as +MAG when q=1 and -MAG when q=0.
- ACC_WIDTH, 8: signed integrator width; must be >= DELTA_WIDTH+1.
- OSR, 8: modulator steps per input sample; must be >= 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_enable  in  1  run request (level)
- i_clear_flags  in  1  single-cycle clear of sticky flags
- i_tick  in  1  modulator step strobe
- i_data  in  DATA_WIDTH  signed input sample
- i_data_valid  in  1  sample valid
- o_data_ready  out  1  sample ready
- o_bit  out  1  quantized output bit
- o_bit_valid  out  1  one-cycle pulse per step
- o_busy  out  1  high while not IDLE
- o_underrun  out  1  sticky: window ended with no new sample
- o_sat  out  1  sticky: integrator clamped

Behaviour:
- Reset (async, any state): FSM=IDLE; integrator=0; q=0; hold/buffer registers and buffer-full flag cleared; step counter=0. All outputs are 0.
- FSM states:
  - IDLE: o_data_ready=0, ticks ignored. When i_enable=1, go to WAIT.
  - WAIT: o_data_ready=1, ticks ignored. On valid&ready, load the hold register, set step counter=0, go to RUN. A tick in the accept cycle is ignored.
  - RUN: o_data_ready = ~buffer_full. A handshake loads the one-entry buffer.
- Step (RUN and i_tick):
  - delta = sext(hold) - (q ? +FEEDBACK_MAG : -FEEDBACK_MAG), DELTA_WIDTH signed.
  - sum = acc + sext(delta), computed at ACC_WIDTH+1.
  - acc <= sum clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. If the clamp was applied, set o_sat.
  - q <= (clamped acc >= 0).
  - o_bit <= new q; o_bit_valid pulses on the following cycle. Latency is tick edge +1 cycle.
- Window end (the step with counter==OSR-1): counter wraps to 0, then:
  - Buffer full: hold <= buffer, buffer emptied.
  - Buffer empty but handshake in the same cycle: hold <= i_data directly (bypass), and the buffer stays empty.
  - Otherwise: hold is kept (zero-order hold), o_underrun is set, and the FSM stays in RUN.
  - If i_enable=0 at window end: go to IDLE, clear acc, q and buffer, and discard any pending sample. A disable mid-window lets the remaining steps complete first.
- Sticky flags:
  - Cleared by i_clear_flags.
  - If a set and a clear occur in the same cycle, the set wins.
- o_busy=1 in WAIT and RUN.
- No modulation occurs outside RUN; acc and q hold their values there.
- Integrator arithmetic is two's complement. No wrap-around ever reaches acc.

Test Plan:
- Reset mid-RUN (i_rst pulsed while acc≠0) -> all outputs 0 immediately (asynchronous); FSM returns to IDLE. After release with i_enable=1, o_data_ready=1 on the next cycle.
- Zero sample (OSR=4, tick every cycle, i_data=0, FEEDBACK_MAG=1) -> acc sequence 1,0,-1,0 and o_bit sequence 1,1,0,1, each bit one cycle after its tick.
- Saturation (ACC_WIDTH=6, OSR=16, i_data=+7) -> acc sequence 8,14,20,26,31,31... and o_bit stays 1. o_sat rises on the 5th step and stays set until i_clear_flags.
- Back-to-back samples (OSR=4, second sample offered mid-window) -> hold swaps at window end with no gap in o_bit_valid, o_underrun=0, and o_data_ready drops for exactly the cycles the buffer is full.
- Underrun (one sample only, OSR=4) -> o_underrun=1 after the 4th step. Modulation continues on the held value and o_data_ready remains 1.
- Disable (i_enable drops after step 2 of OSR=4) -> steps 3 and 4 are still emitted, then IDLE. o_busy=0, acc=0, and a buffered sample is dropped.
